// File: rtl/regfile_pkg.sv
// Shared defaults and types for the register file with pending-write scoreboard.
package regfile_pkg;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_NRD   = 2;
    localparam int DEF_CNT_W = 2;
    localparam int DEF_AW    = $clog2(DEF_DEPTH);

    typedef logic [DEF_AW-1:0]    reg_addr_t;
    typedef logic [DEF_WIDTH-1:0] word_t;
endpackage

// File: rtl/regfile_sb_cnt.sv
// One outstanding-write counter; the caller guarantees inc never hits a full
// counter and dec never hits an empty one.
module regfile_sb_cnt
    import regfile_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_full
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge Clk) begin
        if (Reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !i_dec) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_dec && !i_inc) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = |r_cnt;
    assign o_full = &r_cnt;
endmodule

// File: rtl/regfile_sb.sv
// Register file with write-through read bypass and per-register pending-write
// counters used by decode to detect RAW hazards.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD,
    parameter int CNT_W = DEF_CNT_W,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic                 rsv_valid,
    input  logic [AW-1:0]        rsv_addr,
    output logic                 rsv_ready,
    input  logic                 flush,
    input  logic [NRD*AW-1:0]    raddr,
    output logic [NRD*WIDTH-1:0] rdata,
    output logic [NRD-1:0]       rbusy,
    output logic                 err
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_err;
    logic [CNT_W-1:0] w_cnt [DEPTH];
    logic [DEPTH-1:0] w_busy;
    logic [DEPTH-1:0] w_full;
    logic [DEPTH-1:0] w_inc;
    logic [DEPTH-1:0] w_dec;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_mem[k] <= '0;
            end
        end else if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Ready looks at the pre-update count, so a retiring write cannot free a slot early.
    assign rsv_ready = !flush && !w_full[rsv_addr];

    genvar r;
    generate
        for (r = 0; r < DEPTH; r++) begin : g_cnt
            assign w_inc[r] = rsv_valid && rsv_ready && (rsv_addr == AW'(r));
            assign w_dec[r] = we && (waddr == AW'(r)) && w_busy[r];

            regfile_sb_cnt #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .Clk    (Clk),
                .Reset  (Reset),
                .i_inc  (w_inc[r]),
                .i_dec  (w_dec[r]),
                .i_clr  (flush),
                .o_cnt  (w_cnt[r]),
                .o_busy (w_busy[r]),
                .o_full (w_full[r])
            );
        end
    endgenerate

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else if (we && !flush && !w_busy[waddr]) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

    genvar i;
    generate
        for (i = 0; i < NRD; i++) begin : g_rd
            logic [AW-1:0] w_raddr;
            logic          w_hit;

            assign w_raddr = raddr[i*AW +: AW];
            assign w_hit   = we && (waddr == w_raddr);
            assign rdata[i*WIDTH +: WIDTH] = w_hit ? wdata : r_mem[w_raddr];
            // The last outstanding write retiring now is already visible through the bypass.
            assign rbusy[i] = w_busy[w_raddr] &&
                              !(w_hit && (w_cnt[w_raddr] == CNT_W'(1)));
        end
    endgenerate
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a per-register pending-write scoreboard for the pipelined LC-3 datapath. Provides NRD combinational read ports with write-to-read bypass, one write-back port, and an issue-side reservation port. Per-register counters track outstanding writes so decode can stall on RAW hazards. A flush input discards in-flight reservations on redirect. Sits between decode/issue (reserve, read) and write-back (write).

## Interface
- WIDTH, 16, data width in bits
- DEPTH, 8, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports (≥1)
- CNT_W, 2, pending-counter width; max outstanding writes per register = 2^CNT_W−1
- AW, $clog2(DEPTH), derived address width (localparam)
- Clk  in  1  clock; all state updates on posedge
- Reset  in  1  reset, synchronous, active-high
- we  in  1  write-back valid
- waddr  in  AW  write-back destination
- wdata  in  WIDTH  write-back data
- rsv_valid  in  1  issue requests reservation of rsv_addr
- rsv_addr  in  AW  register to be written by issuing instruction
- rsv_ready  out  1  reservation accepted this cycle
- flush  in  1  clear all pending counters
- raddr  in  NRD×AW  read addresses, packed, port i at [i*AW +: AW]
- rdata  out  NRD×WIDTH  read data, packed
- rbusy  out  NRD  read port i's register has an outstanding write
- err  out  1  sticky: write-back to register with zero pending count

## Operation
- Data array: DEPTH×WIDTH flops. On we, reg[waddr] <= wdata (independent of flush and counters).
- Read: rdata[i] = (we && waddr==raddr[i]) ? wdata : reg[raddr[i]] (write-through bypass).
- Counter cnt[r] per register, CNT_W bits.
  - inc = rsv_valid && rsv_ready && rsv_addr==r; dec = we && waddr==r && cnt[r]!=0.
  - inc && dec: unchanged; inc only: +1; dec only: −1.
  - we to r with cnt[r]==0: no counter change, err <= 1 (held until Reset).
- rsv_ready = !flush && cnt[rsv_addr] != max, evaluated on pre-update count; a same-cycle dec on rsv_addr does not raise ready.
- flush: all cnt <= 0; reservations ignored (rsv_ready=0); the write still lands; err is not set by a write during flush.
- rbusy[i] = cnt[raddr[i]]!=0, except 0 when we && waddr==raddr[i] && cnt==1 (last outstanding write retires this cycle; consumer may issue using bypassed data).

## Timing
- Reset: all registers 0, all cnt 0, err 0. rdata 0, rbusy 0, rsv_ready 1 when inputs idle.
- Reset overrides we, rsv_valid and flush in the same cycle.
- Read latency 0 (combinational); write visible to reads the same cycle via bypass, from the array the next cycle.
- Reservation handshake: single cycle, accepted iff rsv_valid && rsv_ready at posedge; no retry state held internally.
- Counter never wraps: saturation is prevented by rsv_ready, underflow by the err path.

## Structure
- Package regfile_pkg: default WIDTH/DEPTH/CNT_W constants, typedef reg_addr_t (logic [AW-1:0]) and word_t (logic [WIDTH-1:0]).
- Sub-module regfile_sb_cnt: one pending counter (inc, dec, clr, CNT_W param, outputs cnt, busy, full), instantiated DEPTH times in a generate loop.
- Read ports generated NRD times; no other hierarchy.

## Test plan
- Reset, then write R3=16'h1234; next cycle raddr0=3 -> rdata0=16'h1234, rbusy0=0, err=0.
- Same cycle we waddr=5 wdata=16'hBEEF, raddr1=5 -> rdata1=16'hBEEF combinationally; R5 holds BEEF afterwards.
- Reserve R2 three times (CNT_W=2) -> third accepted, fourth cycle rsv_ready=0; one write-back to R2 -> rsv_ready=1 next cycle; rbusy stays 1 until third write.
- cnt[R4]=1, same cycle we waddr=4 and raddr0=4 -> rbusy0=0, rdata0=wdata; with simultaneous reserve of R4 -> cnt stays 1, rbusy0=1.
- Reserve R1, R6; assert flush with rsv_valid on R7 -> rsv_ready=0, all cnt=0, R7 not reserved; later write to R1 -> err=1, stays 1 until Reset.
- Reset asserted mid-stream with cnt[R0]=2 and we=1 -> next cycle all regs 0, cnt 0, err 0.
